// File: rtl/cosim_reset_responder_if.sv
// rtl/cosim_reset_responder_if.sv - reset handshake bundle between cosim driver and design reset tree
interface cosim_reset_responder_if #(
    parameter int CNT_W = 32
);
    logic             rst_req;
    logic             quiesced;
    logic             core_rst;
    logic             rst_ack;
    logic [CNT_W-1:0] run_cycles;
    logic             timeout;

    modport master (
        output rst_req,
        output quiesced,
        input  core_rst,
        input  rst_ack,
        input  run_cycles,
        input  timeout
    );

    modport slave (
        input  rst_req,
        input  quiesced,
        output core_rst,
        output rst_ack,
        output run_cycles,
        output timeout
    );
endinterface

// File: rtl/cosim_reset_responder.sv
// rtl/cosim_reset_responder.sv - drains ESI traffic, holds core reset, acknowledges the cosim driver
// Optional drain timeout: define COSIM_RESET_TIMEOUT_EN.
module cosim_reset_responder #(
    parameter int HOLD_CYCLES     = 4,
    parameter int QUIESCE_TIMEOUT = 256,
    parameter int CNT_W           = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cosim_reset_responder_if.slave  rsp
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    if (HOLD_CYCLES < 1 || QUIESCE_TIMEOUT < 1) begin : g_bad_params
        $error("HOLD_CYCLES and QUIESCE_TIMEOUT must both be at least 1");
    end

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HOLD,
        ST_ACKED
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              core_rst_q;
    logic              rst_ack_q;
    logic [CNT_W-1:0]  run_q;
    logic              drain_expired;

`ifdef COSIM_RESET_TIMEOUT_EN
    localparam int DRAIN_W = $clog2(QUIESCE_TIMEOUT + 1);

    logic [DRAIN_W-1:0] drain_cnt;
    logic               timeout_q;

    assign drain_expired = (drain_cnt == DRAIN_W'(QUIESCE_TIMEOUT - 1));

    // Counts only while DRAIN is being held; any exit from DRAIN leaves it at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (state == ST_DRAIN && !rsp.quiesced && rsp.rst_req && !drain_expired) begin
            drain_cnt <= drain_cnt + 1'b1;
        end else begin
            drain_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else if (state == ST_DRAIN && !rsp.quiesced && rsp.rst_req && drain_expired) begin
            timeout_q <= 1'b1;
        end
    end

    assign rsp.timeout = timeout_q;
`else
    assign drain_expired = 1'b0;
    assign rsp.timeout   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HOLD;
            hold_cnt   <= '0;
            core_rst_q <= 1'b1;
            rst_ack_q  <= 1'b0;
            run_q      <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (run_q != {CNT_W{1'b1}}) begin
                        run_q <= run_q + 1'b1;
                    end
                    if (rsp.rst_req) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Quiesce wins over both withdrawal and timeout in the same cycle.
                    if (rsp.quiesced || (rsp.rst_req && drain_expired)) begin
                        state      <= ST_HOLD;
                        hold_cnt   <= '0;
                        core_rst_q <= 1'b1;
                    end else if (!rsp.rst_req) begin
                        state <= ST_RUN;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state     <= ST_ACKED;
                        hold_cnt  <= '0;
                        rst_ack_q <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_ACKED: begin
                    if (!rsp.rst_req) begin
                        state      <= ST_RUN;
                        core_rst_q <= 1'b0;
                        rst_ack_q  <= 1'b0;
                        run_q      <= '0;
                    end
                end
                default: begin
                    state      <= ST_HOLD;
                    hold_cnt   <= '0;
                    core_rst_q <= 1'b1;
                    rst_ack_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rsp.core_rst   = core_rst_q;
    assign rsp.rst_ack    = rst_ack_q;
    assign rsp.run_cycles = run_q;

endmodule

// File: tb/tb_cosim_reset_responder.sv
// tb/tb_cosim_reset_responder.sv - directed self-checking bench for cosim_reset_responder
module tb_cosim_reset_responder;

    localparam int HOLD_CYCLES     = 4;
    localparam int QUIESCE_TIMEOUT = 8;
    localparam int CNT_W           = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    cosim_reset_responder_if #(.CNT_W(CNT_W)) bus ();

    cosim_reset_responder #(
        .HOLD_CYCLES    (HOLD_CYCLES),
        .QUIESCE_TIMEOUT(QUIESCE_TIMEOUT),
        .CNT_W          (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rsp  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic c, input logic a, input logic [31:0] r,
                        input logic t);
        chk({tag, ".core_rst"}, 32'(bus.core_rst), 32'(c));
        chk({tag, ".rst_ack"}, 32'(bus.rst_ack), 32'(a));
        chk({tag, ".run_cycles"}, 32'(bus.run_cycles), r);
        chk({tag, ".timeout"}, 32'(bus.timeout), 32'(t));
    endtask

    logic exp_to;

    initial begin
        checks       = 0;
        errors       = 0;
        exp_to       = 1'b0;
        rst_n        = 1'b0;
        bus.rst_req  = 1'b0;
        bus.quiesced = 1'b0;
        tick();
        tick();
        outs("reset", 1'b1, 1'b0, 0, 1'b0);
        rst_n = 1'b1;

        // power-on: 4 HOLD cycles, 1-cycle ack pulse, then counting
        for (int i = 1; i <= 3; i++) begin
            tick();
            outs($sformatf("por_hold%0d", i), 1'b1, 1'b0, 0, 1'b0);
        end
        tick();
        outs("por_ack", 1'b1, 1'b1, 0, 1'b0);
        tick();
        outs("por_run0", 1'b0, 1'b0, 0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            outs($sformatf("por_run%0d", i), 1'b0, 1'b0, i, 1'b0);
        end

        // request with quiesced high: 1 DRAIN cycle, 4 HOLD, ack held until withdrawal
        bus.rst_req  = 1'b1;
        bus.quiesced = 1'b1;
        tick();
        outs("q_drain", 1'b0, 1'b0, 4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            outs($sformatf("q_hold%0d", i), 1'b1, 1'b0, 4, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            outs($sformatf("q_ack%0d", i), 1'b1, 1'b1, 4, 1'b0);
        end
        bus.rst_req  = 1'b0;
        bus.quiesced = 1'b0;
        tick();
        outs("q_release", 1'b0, 1'b0, 0, 1'b0);

        // withdrawal after 3 DRAIN cycles: no reset, count resumes
        tick();
        tick();
        outs("ab_pre", 1'b0, 1'b0, 2, 1'b0);
        bus.rst_req = 1'b1;
        tick();
        outs("ab_drain0", 1'b0, 1'b0, 3, 1'b0);
        tick();
        outs("ab_drain1", 1'b0, 1'b0, 3, 1'b0);
        tick();
        outs("ab_drain2", 1'b0, 1'b0, 3, 1'b0);
        bus.rst_req = 1'b0;
        tick();
        outs("ab_run", 1'b0, 1'b0, 3, 1'b0);
        tick();
        outs("ab_run_next", 1'b0, 1'b0, 4, 1'b0);

        // withdrawal on the second HOLD cycle does not shorten the hold
        bus.rst_req  = 1'b1;
        bus.quiesced = 1'b1;
        tick();
        outs("wh_drain", 1'b0, 1'b0, 5, 1'b0);
        tick();
        outs("wh_hold0", 1'b1, 1'b0, 5, 1'b0);
        tick();
        bus.rst_req  = 1'b0;
        bus.quiesced = 1'b0;
        outs("wh_hold1", 1'b1, 1'b0, 5, 1'b0);
        tick();
        outs("wh_hold2", 1'b1, 1'b0, 5, 1'b0);
        tick();
        outs("wh_hold3", 1'b1, 1'b0, 5, 1'b0);
        tick();
        outs("wh_ack", 1'b1, 1'b1, 5, 1'b0);
        tick();
        outs("wh_run", 1'b0, 1'b0, 0, 1'b0);

        // drain with quiesced low
        bus.rst_req = 1'b1;
        tick();
        outs("to_drain0", 1'b0, 1'b0, 1, 1'b0);
`ifdef COSIM_RESET_TIMEOUT_EN
        for (int i = 1; i < QUIESCE_TIMEOUT; i++) begin
            tick();
            outs($sformatf("to_drain%0d", i), 1'b0, 1'b0, 1, 1'b0);
        end
        tick();
        exp_to = 1'b1;
        outs("to_hold", 1'b1, 1'b0, 1, exp_to);
`else
        for (int i = 1; i < 100; i++) begin
            tick();
            chk($sformatf("nto_core%0d", i), 32'(bus.core_rst), 0);
            chk($sformatf("nto_timeout%0d", i), 32'(bus.timeout), 0);
        end
        bus.quiesced = 1'b1;
        tick();
        outs("nto_hold", 1'b1, 1'b0, 1, exp_to);
        bus.quiesced = 1'b0;
`endif
        bus.rst_req = 1'b0;
        for (int i = 1; i < HOLD_CYCLES; i++) begin
            tick();
            outs($sformatf("to_holdn%0d", i), 1'b1, 1'b0, 1, exp_to);
        end
        tick();
        outs("to_ack", 1'b1, 1'b1, 1, exp_to);
        tick();
        outs("to_run", 1'b0, 1'b0, 0, exp_to);

        // saturation at 15 for a 4-bit counter
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14 || i == 15 || i == 20) begin
                chk($sformatf("sat_run%0d", i), 32'(bus.run_cycles), (i > 15) ? 15 : i);
            end
        end

        // async reset pulse while ACKED
        bus.rst_req  = 1'b1;
        bus.quiesced = 1'b1;
        tick();
        for (int i = 0; i < HOLD_CYCLES; i++) tick();
        tick();
        outs("ar_ack", 1'b1, 1'b1, 15, exp_to);
        #2;
        rst_n = 1'b0;
        #1;
        outs("ar_async", 1'b1, 1'b0, 0, 1'b0);
        bus.rst_req  = 1'b0;
        bus.quiesced = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            outs($sformatf("ar_hold%0d", i), 1'b1, 1'b0, 0, 1'b0);
        end
        tick();
        outs("ar_ackp", 1'b1, 1'b1, 0, 1'b0);
        tick();
        outs("ar_run0", 1'b0, 1'b0, 0, 1'b0);
        tick();
        outs("ar_run1", 1'b0, 1'b0, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cosim_reset_responder.md
# cosim_reset_responder

Design-side end of the cosimulation reset handshake. The testbench driver raises a reset request; this block drains in-flight ESI traffic, holds the design's core reset for a fixed number of cycles, then acknowledges back to the driver. It releases core reset only when the driver withdraws the request. It sits inside the cosim top, between the driver's clock/reset pins and the design's reset tree, and also reports cycles elapsed since the last release.

## Interface
- HOLD_CYCLES, 4: cycles `core_rst` is held before acknowledge; must be ≥1.
- QUIESCE_TIMEOUT, 256: maximum DRAIN cycles before forced reset; must be ≥1.
- CNT_W, 32: width of `run_cycles`.

- clk  in  1  sole clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rst_req  in  1  reset request from the driver; level, synchronous to clk.
- quiesced  in  1  high when all ESI endpoints have no in-flight messages.
- core_rst  out  1  active-high reset to the design; registered.
- rst_ack  out  1  acknowledge to the driver; registered.
- run_cycles  out  CNT_W  cycles spent in RUN since the last release; saturating.
- timeout  out  1  sticky; set when a drain was cut short by the timeout.

## Operation
- States: RUN, DRAIN, HOLD, ACKED.
- Async reset (rst_n=0):
  - state=HOLD, hold counter=0, drain counter=0.
  - core_rst=1, rst_ack=0, run_cycles=0, timeout=0.
- RUN:
  - core_rst=0, rst_ack=0.
  - run_cycles increments each cycle and saturates at all-ones.
  - rst_req=1 → DRAIN.
- DRAIN:
  - core_rst=0; the drain counter increments each cycle.
  - quiesced=1 → HOLD (has priority over the timeout).
  - rst_req=0 → RUN with no reset; run_cycles keeps counting from its current value; drain counter cleared.
  - Drain counter reaches QUIESCE_TIMEOUT-1 with quiesced=0 → HOLD and set timeout.
- HOLD:
  - core_rst=1.
  - Stays exactly HOLD_CYCLES cycles, then → ACKED.
  - rst_req is ignored; a withdrawn request does not shorten the hold.
- ACKED:
  - core_rst=1, rst_ack=1.
  - Stays while rst_req=1.
  - rst_req=0 → RUN; run_cycles cleared to 0 on entry.
- rst_ack=1 guarantees that core_rst has been high for at least HOLD_CYCLES consecutive cycles.
- timeout clears only on rst_n.

## Timing
- All outputs are registered and change on the clk edge that enters the new state.
- RUN→DRAIN: 1 cycle after rst_req is sampled high.
- DRAIN with quiesced already high: exactly 1 DRAIN cycle.
- core_rst rises on the edge entering HOLD. rst_ack rises HOLD_CYCLES edges later.
- core_rst and rst_ack fall on the same edge, 1 cycle after rst_req is sampled low in ACKED.
- Power-on path: after rst_n deasserts, HOLD runs HOLD_CYCLES cycles, then ACKED. If rst_req=0 there, ACKED lasts exactly 1 cycle and rst_ack pulses once.
- Timeout path: the worst-case DRAIN length is QUIESCE_TIMEOUT cycles.
- run_cycles reads 1 on the first cycle after RUN entry has been registered.
- rst_n assertion mid-operation, in any state: outputs go immediately (asynchronously) to their reset values, and the sequence restarts at HOLD.

## Configuration
- `COSIM_RESET_TIMEOUT_EN` defined:
  - DRAIN timeout logic and the drain counter are present.
  - timeout behaves as described above.
- `COSIM_RESET_TIMEOUT_EN` undefined:
  - DRAIN waits for quiesced=1 or rst_req=0 with no bound.
  - The drain counter is removed and timeout is tied to 0.

## Test plan
- Power-on, HOLD_CYCLES=4, rst_req=0: core_rst=1 for 4 cycles after rst_n rises, then rst_ack pulses for 1 cycle, then core_rst=0 and run_cycles counts 1,2,3…
- Running, rst_req=1 with quiesced=1: DRAIN lasts 1 cycle and core_rst=1 for 4 cycles. Then rst_ack=1 and holds until rst_req=0. Then core_rst=rst_ack=0 on the next edge and run_cycles=0.
- Timeout, macro defined, QUIESCE_TIMEOUT=8, quiesced=0: exactly 8 DRAIN cycles, then HOLD and timeout=1, which stays set after return to RUN. With the macro undefined, the block stays in DRAIN for 100 cycles and timeout stays 0.
- rst_req dropped after 3 DRAIN cycles: back to RUN, core_rst never asserts, and run_cycles resumes from its pre-drain value.
- rst_req dropped on the second HOLD cycle: the full 4 HOLD cycles complete, then a 1-cycle rst_ack pulse, then RUN.
- CNT_W=4, long run: run_cycles saturates at 15. rst_n pulsed during ACKED clears all outputs asynchronously and the HOLD sequence restarts.
